// File: rtl/register_file_mp_if.sv
// Write/read port bundle of the multi-port register file.
// The master drives the write and read requests, and the slave returns the registered read data and flags.
interface register_file_mp_if #(
    parameter int unsigned WIDTH = 10,
    parameter int unsigned AW    = 3
);
    logic [WIDTH-1:0] D;
    logic             ENW;
    logic [1:0]       WOP;
    logic [AW-1:0]    WRA;
    logic             ENR0;
    logic [AW-1:0]    RDA0;
    logic             ENR1;
    logic [AW-1:0]    RDA1;
    logic             CLR;
    logic [WIDTH-1:0] Q0;
    logic [WIDTH-1:0] Q1;
    logic             V0;
    logic             V1;
    logic             OVF;

    modport master (
        output D, ENW, WOP, WRA, ENR0, RDA0, ENR1, RDA1, CLR,
        input  Q0, Q1, V0, V1, OVF
    );

    modport slave (
        input  D, ENW, WOP, WRA, ENR0, RDA0, ENR1, RDA1, CLR,
        output Q0, Q1, V0, V1, OVF
    );
endinterface

// File: rtl/register_file_mp.sv
// Register file with one write port (load/accumulate/set/clear ops) and two read ports.
// The read ports are registered and enable-gated, with a write-through bypass. All state changes on the falling CLKb edge.
module register_file_mp #(
    parameter int unsigned WIDTH    = 10,
    parameter int unsigned DEPTH    = 8,
    parameter bit          ZERO_REG = 1'b0
) (
    input logic               CLKb,
    input logic               RSTb,
    register_file_mp_if.slave bus
);
    localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned SLOTS = 1 << AW;

    logic [WIDTH-1:0] regs     [SLOTS];
    logic [WIDTH-1:0] regs_nxt [SLOTS];
    logic [SLOTS-1:0] flags;
    logic [SLOTS-1:0] flags_nxt;
    logic             ovf;
    logic             ovf_nxt;
    logic [WIDTH-1:0] q0, q1, q0_nxt, q1_nxt;
    logic             v0, v1, v0_nxt, v1_nxt;
    logic [WIDTH:0]   sum_c;
    logic [WIDTH-1:0] wval_c;
    logic             wr_ok_c;

    function automatic logic in_range(input logic [AW-1:0] a);
        return (AW+1)'(a) < (AW+1)'(DEPTH);
    endfunction

    // Write-op result and the state after this edge's write/clear
    always_comb begin
        regs_nxt  = regs;
        flags_nxt = flags;
        ovf_nxt   = ovf;
        sum_c     = {1'b0, regs[bus.WRA]} + {1'b0, bus.D};
        wval_c    = bus.D;
        wr_ok_c   = bus.ENW && in_range(bus.WRA) && !(ZERO_REG && bus.WRA == '0);
        unique case (bus.WOP)
            2'b00:   wval_c = bus.D;
            2'b01:   wval_c = sum_c[WIDTH-1:0];
            2'b10:   wval_c = regs[bus.WRA] | bus.D;
            default: wval_c = regs[bus.WRA] & ~bus.D;
        endcase
        if (bus.CLR) begin
            for (int i = 0; i < int'(SLOTS); i++) regs_nxt[i] = '0;
            flags_nxt = '0;
            ovf_nxt   = 1'b0;
        end else if (wr_ok_c) begin
            regs_nxt[bus.WRA]  = wval_c;
            flags_nxt[bus.WRA] = 1'b1;
            ovf_nxt            = (bus.WOP == 2'b01) ? sum_c[WIDTH] : 1'b0;
        end
    end

    // Read ports look at post-write state, which gives the bypass for free
    always_comb begin
        q0_nxt = '0;
        v0_nxt = 1'b0;
        q1_nxt = '0;
        v1_nxt = 1'b0;
        if (in_range(bus.RDA0)) begin
            if (ZERO_REG && bus.RDA0 == '0) begin
                v0_nxt = 1'b1;
            end else begin
                q0_nxt = regs_nxt[bus.RDA0];
                v0_nxt = flags_nxt[bus.RDA0];
            end
        end
        if (in_range(bus.RDA1)) begin
            if (ZERO_REG && bus.RDA1 == '0) begin
                v1_nxt = 1'b1;
            end else begin
                q1_nxt = regs_nxt[bus.RDA1];
                v1_nxt = flags_nxt[bus.RDA1];
            end
        end
    end

    always_ff @(negedge CLKb or negedge RSTb) begin
        if (!RSTb) begin
            for (int i = 0; i < int'(SLOTS); i++) regs[i] <= '0;
            flags <= '0;
            ovf   <= 1'b0;
            q0    <= '0;
            q1    <= '0;
            v0    <= 1'b0;
            v1    <= 1'b0;
        end else begin
            regs  <= regs_nxt;
            flags <= flags_nxt;
            ovf   <= ovf_nxt;
            if (bus.ENR0) begin
                q0 <= q0_nxt;
                v0 <= v0_nxt;
            end
            if (bus.ENR1) begin
                q1 <= q1_nxt;
                v1 <= v1_nxt;
            end
        end
    end

    assign bus.Q0  = q0;
    assign bus.Q1  = q1;
    assign bus.V0  = v0;
    assign bus.V1  = v1;
    assign bus.OVF = ovf;
endmodule

// File: tb/tb_register_file_mp.sv
// Directed bench for register_file_mp.
// Covers the default build and a ZERO_REG=1 build. Outputs are sampled 1 time unit after each falling edge.
module tb_register_file_mp;
    logic CLKb = 1'b1;
    logic RSTb = 1'b0;
    int   checks = 0;
    int   errors = 0;

    register_file_mp_if #(.WIDTH(10), .AW(3)) bus ();
    register_file_mp_if #(.WIDTH(10), .AW(3)) zbus ();

    register_file_mp #(.WIDTH(10), .DEPTH(8), .ZERO_REG(1'b0)) dut (
        .CLKb(CLKb), .RSTb(RSTb), .bus(bus.slave)
    );
    register_file_mp #(.WIDTH(10), .DEPTH(8), .ZERO_REG(1'b1)) zdut (
        .CLKb(CLKb), .RSTb(RSTb), .bus(zbus.slave)
    );

    always #5 CLKb = ~CLKb;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge CLKb);
        #1;
    endtask

    // Drive all request fields of the main port, then take one edge
    task automatic cyc(input logic enw, input logic [1:0] wop, input logic [2:0] wra, input logic [9:0] d,
                       input logic enr0, input logic [2:0] rda0, input logic enr1, input logic [2:0] rda1,
                       input logic clr);
        bus.ENW = enw; bus.WOP = wop; bus.WRA = wra; bus.D = d;
        bus.ENR0 = enr0; bus.RDA0 = rda0; bus.ENR1 = enr1; bus.RDA1 = rda1; bus.CLR = clr;
        tick();
    endtask

    initial begin
        bus.ENW = 0; bus.WOP = 0; bus.WRA = 0; bus.D = 0; bus.ENR0 = 0; bus.RDA0 = 0;
        bus.ENR1 = 0; bus.RDA1 = 0; bus.CLR = 0;
        zbus.ENW = 0; zbus.WOP = 0; zbus.WRA = 0; zbus.D = 0; zbus.ENR0 = 0; zbus.RDA0 = 0;
        zbus.ENR1 = 0; zbus.RDA1 = 0; zbus.CLR = 0;

        // Reset state
        tick(); tick();
        check("rst_q0", 32'(bus.Q0), 32'h0);
        check("rst_ovf", 32'(bus.OVF), 32'h0);
        RSTb = 1'b1;

        // Build up non-zero Q0/OVF, then assert reset between edges
        cyc(1, 2'b00, 3'd2, 10'h3F0, 0, 3'd0, 0, 3'd0, 0);
        cyc(1, 2'b01, 3'd2, 10'h020, 1, 3'd2, 0, 3'd0, 0);
        check("pre_rst_q0", 32'(bus.Q0), 32'h010);
        check("pre_rst_ovf", 32'(bus.OVF), 32'h1);
        #3 RSTb = 1'b0;
        #1;
        check("async_rst_q0", 32'(bus.Q0), 32'h0);
        check("async_rst_v0", 32'(bus.V0), 32'h0);
        check("async_rst_ovf", 32'(bus.OVF), 32'h0);
        #2 RSTb = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc(0, 2'b00, 3'd0, 10'h0, 1, 3'(2*i), 1, 3'(2*i+1), 0);
            check("rst_read_q0", 32'(bus.Q0), 32'h0);
            check("rst_read_v0", 32'(bus.V0), 32'h0);
            check("rst_read_q1", 32'(bus.Q1), 32'h0);
            check("rst_read_v1", 32'(bus.V1), 32'h0);
        end

        // Load then read; disabled port holds
        cyc(1, 2'b00, 3'd3, 10'h155, 0, 3'd0, 0, 3'd0, 0);
        cyc(0, 2'b00, 3'd0, 10'h0, 1, 3'd3, 0, 3'd0, 0);
        check("load_q0", 32'(bus.Q0), 32'h155);
        check("load_v0", 32'(bus.V0), 32'h1);
        cyc(0, 2'b00, 3'd0, 10'h0, 0, 3'd5, 0, 3'd0, 0);
        check("hold_q0", 32'(bus.Q0), 32'h155);
        check("hold_v0", 32'(bus.V0), 32'h1);

        // Write-through bypass to port 1
        cyc(1, 2'b00, 3'd6, 10'h2AA, 0, 3'd0, 1, 3'd6, 0);
        check("bypass_q1", 32'(bus.Q1), 32'h2AA);
        check("bypass_v1", 32'(bus.V1), 32'h1);

        // Accumulate wrap and OVF lifecycle
        cyc(1, 2'b00, 3'd2, 10'h3F0, 0, 3'd0, 0, 3'd0, 0);
        cyc(1, 2'b01, 3'd2, 10'h020, 0, 3'd0, 0, 3'd0, 0);
        check("acc_ovf", 32'(bus.OVF), 32'h1);
        cyc(0, 2'b00, 3'd0, 10'h0, 1, 3'd2, 0, 3'd0, 0);
        check("acc_q0", 32'(bus.Q0), 32'h010);
        check("acc_ovf_sticky", 32'(bus.OVF), 32'h1);
        cyc(1, 2'b00, 3'd2, 10'h001, 0, 3'd0, 0, 3'd0, 0);
        check("load_clears_ovf", 32'(bus.OVF), 32'h0);
        cyc(1, 2'b01, 3'd5, 10'h100, 1, 3'd5, 0, 3'd0, 0);
        check("acc_nowrap_q0", 32'(bus.Q0), 32'h100);
        check("acc_nowrap_ovf", 32'(bus.OVF), 32'h0);

        // Set bits, then clear bits with both ports reading r4 through the bypass
        cyc(1, 2'b00, 3'd4, 10'h0F0, 0, 3'd0, 0, 3'd0, 0);
        cyc(1, 2'b10, 3'd4, 10'h00F, 1, 3'd4, 0, 3'd0, 0);
        check("set_q0", 32'(bus.Q0), 32'h0FF);
        cyc(1, 2'b11, 3'd4, 10'h0C3, 1, 3'd4, 1, 3'd4, 0);
        check("clrbits_q0", 32'(bus.Q0), 32'h03C);
        check("clrbits_q1", 32'(bus.Q1), 32'h03C);

        // CLR beats a simultaneous write; a disabled port keeps its value
        cyc(1, 2'b01, 3'd1, 10'h3FF, 1, 3'd1, 0, 3'd0, 1);
        check("clr_q0", 32'(bus.Q0), 32'h0);
        check("clr_v0", 32'(bus.V0), 32'h0);
        check("clr_q1_held", 32'(bus.Q1), 32'h03C);
        check("clr_ovf", 32'(bus.OVF), 32'h0);
        cyc(0, 2'b00, 3'd0, 10'h0, 1, 3'd6, 1, 3'd4, 0);
        check("after_clr_q0", 32'(bus.Q0), 32'h0);
        check("after_clr_v0", 32'(bus.V0), 32'h0);
        check("after_clr_q1", 32'(bus.Q1), 32'h0);
        check("after_clr_v1", 32'(bus.V1), 32'h0);

        // Hardwired zero register build
        zbus.ENW = 1; zbus.WOP = 2'b00; zbus.WRA = 3'd0; zbus.D = 10'h3FF;
        zbus.ENR0 = 1; zbus.RDA0 = 3'd0; zbus.ENR1 = 1; zbus.RDA1 = 3'd1;
        tick();
        check("zero_q0", 32'(zbus.Q0), 32'h0);
        check("zero_v0", 32'(zbus.V0), 32'h1);
        check("zero_q1", 32'(zbus.Q1), 32'h0);
        check("zero_v1", 32'(zbus.V1), 32'h0);
        zbus.ENW = 0;
        tick();
        check("zero_q0_after", 32'(zbus.Q0), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
